// File: rtl/mips32_tb_pkg.sv
// Shared types and constants for the mips32 vector sequencer.
// The FSM state encoding also appears on the sequencer's debug output.
package mips32_tb_pkg;

  localparam int DEFAULT_DATA_W = 32;

  // The canonical NOP is sll $0,$0,0, which encodes as all zeros.
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mips32_vector_ram.sv
// Vector store holding {instruction, expected result} pairs.
// It has one synchronous write port, one asynchronous read port, and no reset.
module mips32_vector_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [2*DATA_W-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [2*DATA_W-1:0] mem [DEPTH];

  // Writes to indices beyond DEPTH are discarded when DEPTH < 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_L)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mips32_test_sequencer.sv
// Clocked engine that streams stored vectors into the R-type datapath and checks results.
// It tracks pass and fail counts and records the first mismatch.
module mips32_test_sequencer
  import mips32_tb_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [DATA_W-1:0] load_expected,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              stop_on_fail,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] instr_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pass_count,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail_idx,
  output logic [DATA_W-1:0] first_fail_res,
  output logic [2:0]        state_dbg
);

  localparam int              HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP   = DATA_W'(MIPS_NOP);

  seq_state_t          state;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   last_idx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                stop_r;
  logic [2*DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0]   ram_instr;
  logic [DATA_W-1:0]   ram_expected;
  logic [ADDR_W:0]     run_len;
  logic [ADDR_W:0]     run_last;
  logic                mismatch;

  assign busy      = (state == ISSUE) || (state == WAIT) || (state == CHECK);
  assign done      = (state == DONE);
  assign state_dbg = state;

  mips32_vector_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (load_en && !busy),
    .waddr (load_addr),
    .wdata ({load_instr, load_expected}),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  assign ram_instr    = ram_rdata[2*DATA_W-1:DATA_W];
  assign ram_expected = ram_rdata[DATA_W-1:0];
  assign mismatch     = (result != ram_expected);

  // Requested lengths above DEPTH are clamped, so the index never wraps.
  assign run_len  = (num_vec > DEPTH_L) ? DEPTH_L : num_vec;
  assign run_last = run_len - (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      last_idx       <= '0;
      hold_cnt       <= '0;
      stop_r         <= 1'b0;
      instr_out      <= NOP;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_res <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx            <= '0;
            last_idx       <= run_last[ADDR_W-1:0];
            stop_r         <= stop_on_fail;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_res <= '0;
            state          <= (num_vec == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          instr_out <= ram_instr;
          hold_cnt  <= HOLD_W'(HOLD_CYCLES - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (hold_cnt == '0) begin
            state <= CHECK;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            fail_count <= fail_count + (ADDR_W+1)'(1);
            if (fail_count == '0) begin
              first_fail_idx <= idx;
              first_fail_res <= result;
            end
          end else begin
            pass_count <= pass_count + (ADDR_W+1)'(1);
          end
          if ((idx == last_idx) || (mismatch && stop_r)) begin
            instr_out <= NOP;
            state     <= DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_test_sequencer.sv
// Directed and randomized checks of the vector sequencer.
// A behavioural datapath model supplies the result bus.
module tb_mips32_test_sequencer;

  localparam int H  = 3;
  localparam int DW = 32;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_instr = '0;
  logic [DW-1:0] load_expected = '0;
  logic          start = 1'b0;
  logic [AW:0]   num_vec = '0;
  logic          stop_on_fail = 1'b0;
  logic [DW-1:0] result;
  logic [DW-1:0] instr_out;
  logic          busy;
  logic          done;
  logic [AW:0]   pass_count;
  logic [AW:0]   fail_count;
  logic [AW-1:0] first_fail_idx;
  logic [DW-1:0] first_fail_res;
  logic [2:0]    state_dbg;

  int tests = 0;
  int fails = 0;

  logic [31:0] regs [32];
  logic [31:0] vec_instr [D];
  logic [31:0] vec_exp [D];
  logic [31:0] exp_q [$];
  logic [31:0] prev_instr = '0;
  logic [5:0]  functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  always #5 clk = ~clk;

  mips32_test_sequencer #(
    .DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_expected(load_expected), .start(start),
    .num_vec(num_vec), .stop_on_fail(stop_on_fail), .result(result),
    .instr_out(instr_out), .busy(busy), .done(done), .pass_count(pass_count),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_res(first_fail_res), .state_dbg(state_dbg)
  );

  // Single-cycle R-type datapath behaviour.
  function automatic logic [31:0] dp_eval(input logic [31:0] ins);
    logic [31:0] a;
    logic [31:0] b;
    a = regs[ins[25:21]];
    b = regs[ins[20:16]];
    case (ins[5:0])
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return b << ins[10:6];
    endcase
  endfunction

  assign result = dp_eval(instr_out);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every new non-NOP instruction must be the next one the model expects.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_out != prev_instr && instr_out != 32'h0) begin
        if (exp_q.size() == 0) check("unexpected_issue", instr_out, 32'h0);
        else check("issue_order", instr_out, exp_q.pop_front());
      end
    end
    prev_instr = instr_out;
  end

  function automatic logic [31:0] make_instr(input int i);
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    rs = 5'($urandom_range(0, 31));
    rt = 5'($urandom_range(0, 31));
    rd = 5'(i + 8);
    return {6'h00, rs, rt, rd, 5'h00, functs[$urandom_range(0, 4)]};
  endfunction

  task automatic load_vec(input int a, input logic [31:0] ins, input logic [31:0] exp);
    load_en = 1'b1;
    load_addr = AW'(a);
    load_instr = ins;
    load_expected = exp;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic fill(input int n, input int corrupt);
    for (int i = 0; i < n; i++) begin
      vec_instr[i] = make_instr(i);
      vec_exp[i] = dp_eval(vec_instr[i]);
      if (i == corrupt) vec_exp[i] = vec_exp[i] ^ 32'h0000_0001;
      load_vec(i, vec_instr[i], vec_exp[i]);
    end
  endtask

  task automatic run(input int nv, input bit stop, input bit interfere, input int co_load,
                     input string tag);
    int n_eff, n_run, e_pass, e_fail, e_fidx, cyc;
    logic [31:0] e_fres;
    n_eff = (nv > D) ? D : nv;
    n_run = 0; e_pass = 0; e_fail = 0; e_fidx = 0; e_fres = '0;
    for (int i = 0; i < n_eff; i++) begin
      n_run++;
      exp_q.push_back(vec_instr[i]);
      if (dp_eval(vec_instr[i]) == vec_exp[i]) e_pass++;
      else begin
        if (e_fail == 0) begin
          e_fidx = i;
          e_fres = dp_eval(vec_instr[i]);
        end
        e_fail++;
        if (stop) break;
      end
    end
    num_vec = 5'(nv);
    stop_on_fail = stop;
    if (co_load >= 0) begin
      load_en = 1'b1;
      load_addr = AW'(co_load);
      load_instr = vec_instr[co_load];
      load_expected = vec_exp[co_load];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_en = 1'b0;
    cyc = 0;
    while (!done && cyc < 2000) begin
      if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (interfere && cyc == 2) begin
        load_en = 1'b1;
        load_addr = '0;
        load_instr = 32'hdead_beef;
        load_expected = 32'h1234_5678;
        start = 1'b1;
      end else begin
        load_en = 1'b0;
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    load_en = 1'b0;
    start = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(n_run * (H + 2)));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass_count), 32'(e_pass));
    check({tag, "_fail"}, 32'(fail_count), 32'(e_fail));
    if (e_fail != 0) begin
      check({tag, "_ff_idx"}, 32'(first_fail_idx), 32'(e_fidx));
      check({tag, "_ff_res"}, first_fail_res, e_fres);
    end
    check({tag, "_nop"}, instr_out, 32'h0);
    @(negedge clk);
    check({tag, "_all_issued"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    regs[4] = 32'd5;
    regs[5] = 32'd4;

    // Reset values while held in reset.
    #12;
    check("rst_instr", instr_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-WAIT aborts at once.
    fill(2, -1);
    exp_q.push_back(vec_instr[0]);
    num_vec = 5'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_instr", instr_out, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pass", 32'(pass_count), 32'd0);
    check("midrst_fail", 32'(fail_count), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-vector pass run; vector 1 is written in the same cycle as start.
    vec_instr[0] = 32'h0085_1022; vec_exp[0] = 32'd1;
    vec_instr[1] = 32'h0085_1020; vec_exp[1] = 32'd9;
    load_vec(0, vec_instr[0], vec_exp[0]);
    load_vec(1, 32'hffff_ffff, 32'hffff_ffff);
    run(2, 1'b0, 1'b0, 1, "two_pass");

    // Corrupted expectation at index 1, with and without stop_on_fail.
    fill(4, 1);
    run(4, 1'b0, 1'b0, -1, "mis_nostop");
    run(4, 1'b1, 1'b0, -1, "mis_stop");

    // Zero-length run and saturated length.
    run(0, 1'b0, 1'b0, -1, "zero_len");
    fill(16, -1);
    run(31, 1'b0, 1'b0, -1, "saturate");

    // Load and start while busy must be dropped; the rerun confirms RAM is intact.
    fill(3, -1);
    run(3, 1'b0, 1'b1, -1, "interfere");
    run(3, 1'b0, 1'b0, -1, "ram_intact");

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 16);
      fill(n, $urandom_range(0, 20));
      run(n, 1'($urandom_range(0, 1)), 1'b0, -1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
